mem_bus_arbiter: RTL and testbench

Two-master arbiter that shares the single memory/MMIO decode bus between the picorv32 CPU (master 0) and a second bus master such as a DMA or debug engine (master 1).
- Both masters use the valid/ready memory interface; the downstream slave side feeds the existing address-decode mux unchanged.
- Grants are round-robin per transaction, and the grant is held for the whole transaction.
- A timeout terminates hung accesses with 32'h0 read data, which the CPU decodes as an illegal instruction and traps on.

---
 rtl/mem_bus_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter onto the decode bus; ready 2 cycles after valid on a 0-wait slave, grant held until DONE.
// Hung slaves are cut off after TIMEOUT_CYCLES with zero read data; define ARB_FIXED_PRIO_EN to make m0 always win ties.
module mem_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        timeout_flag,
  input  logic        timeout_clr
);

  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_ACCESS = 2'd1;
  localparam logic [1:0]  ST_DONE   = 2'd2;
  localparam logic [15:0] TERM_CNT  = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  r_state;
  logic        r_owner;
  logic        r_last_owner;
  logic [15:0] r_cnt;
  logic [31:0] r_m0_rdata;
  logic [31:0] r_m1_rdata;
  logic        r_timeout_flag;

  logic w_pick;
  logic w_own_vld;
  logic w_in_access;
  logic w_tmo;

`ifdef ARB_FIXED_PRIO_EN
  assign w_pick = m1_valid && !m0_valid;
`else
  assign w_pick = (m0_valid && m1_valid) ? ~r_last_owner : m1_valid;
`endif

  assign w_own_vld   = r_owner ? m1_valid : m0_valid;
  assign w_in_access = (r_state == ST_ACCESS);
  assign w_tmo       = w_in_access && w_own_vld && !s_ready && (r_cnt == TERM_CNT);

  // Slave side is a pure mux of the owner; zero outside ACCESS so the decoder sees a quiet bus.
  assign s_valid = w_in_access && w_own_vld;
  assign s_instr = w_in_access && (r_owner ? m1_instr : m0_instr);
  assign s_addr  = w_in_access ? (r_owner ? m1_addr  : m0_addr)  : 32'h0;
  assign s_wdata = w_in_access ? (r_owner ? m1_wdata : m0_wdata) : 32'h0;
  assign s_wstrb = w_in_access ? (r_owner ? m1_wstrb : m0_wstrb) : 4'h0;

  assign grant        = (r_state == ST_IDLE) ? 2'b00 : (r_owner ? 2'b10 : 2'b01);
  assign m0_ready     = (r_state == ST_DONE) && !r_owner;
  assign m1_ready     = (r_state == ST_DONE) &&  r_owner;
  assign m0_rdata     = r_m0_rdata;
  assign m1_rdata     = r_m1_rdata;
  assign timeout_flag = r_timeout_flag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_cnt        <= 16'h0;
      r_m0_rdata   <= 32'h0;
      r_m1_rdata   <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= 16'h0;
          if (m0_valid || m1_valid) begin
            r_owner <= w_pick;
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!w_own_vld) begin
            r_state <= ST_IDLE;
            r_cnt   <= 16'h0;
          end else if (s_ready) begin
            if (r_owner) r_m1_rdata <= s_rdata;
            else         r_m0_rdata <= s_rdata;
            r_last_owner <= r_owner;
            r_state      <= ST_DONE;
          end else if (r_cnt == TERM_CNT) begin
            // Zero data decodes as an illegal instruction, so a hung fetch traps.
            if (r_owner) r_m1_rdata <= 32'h0;
            else         r_m0_rdata <= 32'h0;
            r_last_owner <= r_owner;
            r_state      <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_cnt   <= 16'h0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= 16'h0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         r_timeout_flag <= 1'b0;
    else if (timeout_clr) r_timeout_flag <= 1'b0;
    else if (w_tmo)       r_timeout_flag <= 1'b1;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter built with an 8-cycle timeout.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_valid, m0_instr, m1_valid, m1_instr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_instr, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  grant;
  logic        timeout_flag, timeout_clr;

  int n_pass = 0;
  int n_tot  = 0;
  logic [1:0] exp_g [0:3];
  int k, m0p, m1p;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant), .timeout_flag(timeout_flag), .timeout_clr(timeout_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; timeout_clr = 1'b0;
    m0_valid = 1'b0; m0_instr = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_instr = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    s_ready = 1'b0; s_rdata = '0;
`ifdef ARB_FIXED_PRIO_EN
    exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01; exp_g[3] = 2'b01;
`else
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
`endif
    tick(); tick();
    chk("rst_grant", {30'b0, grant}, 32'h0);
    chk("rst_s_valid", {31'b0, s_valid}, 32'h0);
    chk("rst_ready", {30'b0, m1_ready, m0_ready}, 32'h0);
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    chk("rst_flag", {31'b0, timeout_flag}, 32'h0);
    reset_n = 1'b1;

    // Single uncontended m0 read with a 0-wait slave
    m0_valid = 1'b1; m0_addr = 32'hC300_0000;
    tick();
    chk("rd_s_valid", {31'b0, s_valid}, 32'h1);
    chk("rd_grant", {30'b0, grant}, 32'h1);
    chk("rd_s_addr", s_addr, 32'hC300_0000);
    chk("rd_early_ready", {31'b0, m0_ready}, 32'h0);
    s_ready = 1'b1; s_rdata = 32'h1234_5678;
    tick();
    chk("rd_m0_ready", {31'b0, m0_ready}, 32'h1);
    chk("rd_m0_rdata", m0_rdata, 32'h1234_5678);
    chk("rd_done_grant", {30'b0, grant}, 32'h1);
    chk("rd_done_s_valid", {31'b0, s_valid}, 32'h0);
    m0_valid = 1'b0; s_ready = 1'b0;
    tick();
    chk("rd_idle_ready", {31'b0, m0_ready}, 32'h0);
    chk("rd_idle_grant", {30'b0, grant}, 32'h0);

    // Contention from reset, both masters re-requesting continuously
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    m0_valid = 1'b1; m1_valid = 1'b1; s_ready = 1'b1; s_rdata = 32'hA5A5_0001;
    k = 0; m0p = 0; m1p = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (s_valid) begin
        if (k < 4) chk("rr_grant", {30'b0, grant}, {30'b0, exp_g[k]});
        k++;
      end
      if (m0_ready) m0p++;
      if (m1_ready) m1p++;
    end
    chk("rr_access_count", k, 32'd4);
`ifdef ARB_FIXED_PRIO_EN
    chk("rr_m0_pulses", m0p, 32'd4);
    chk("rr_m1_pulses", m1p, 32'd0);
`else
    chk("rr_m0_pulses", m0p, 32'd2);
    chk("rr_m1_pulses", m1p, 32'd2);
`endif
    m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
    tick();

    // m1 write with 3 wait states
    m1_valid = 1'b1; m1_addr = 32'h0000_1000; m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 4'hF;
    s_rdata = 32'h0000_BEEF;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("wr_s_wstrb", {28'b0, s_wstrb}, 32'hF);
      chk("wr_s_wdata", s_wdata, 32'hDEAD_BEEF);
      chk("wr_grant", {30'b0, grant}, 32'h2);
      chk("wr_no_ready", {30'b0, m1_ready, m0_ready}, 32'h0);
      if (i == 3) s_ready = 1'b1;
      tick();
    end
    chk("wr_m1_ready", {30'b0, m1_ready, m0_ready}, 32'h2);
    chk("wr_m1_rdata", m1_rdata, 32'h0000_BEEF);
    m1_valid = 1'b0; m1_wstrb = 4'h0; s_ready = 1'b0;
    tick();
    chk("wr_idle_ready", {30'b0, m1_ready, m0_ready}, 32'h0);

    // Forced completion after 8 ACCESS cycles
    m0_valid = 1'b1; s_rdata = 32'hFFFF_FFFF;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("to_access", {30'b0, s_valid, m0_ready}, 32'h2);
      tick();
    end
    chk("to_m0_ready", {31'b0, m0_ready}, 32'h1);
    chk("to_m0_rdata", m0_rdata, 32'h0);
    chk("to_flag_set", {31'b0, timeout_flag}, 32'h1);
    chk("to_m1_rdata_held", m1_rdata, 32'h0000_BEEF);
    m0_valid = 1'b0;
    tick(); tick(); tick();
    chk("to_flag_sticky", {31'b0, timeout_flag}, 32'h1);
    timeout_clr = 1'b1;
    tick();
    timeout_clr = 1'b0;
    chk("to_flag_clr", {31'b0, timeout_flag}, 32'h0);

    // s_ready arriving on the terminal count wins
    m0_valid = 1'b1; s_rdata = 32'hCAFE_0001;
    tick();
    repeat (7) tick();
    s_ready = 1'b1;
    tick();
    chk("tie_m0_ready", {31'b0, m0_ready}, 32'h1);
    chk("tie_m0_rdata", m0_rdata, 32'hCAFE_0001);
    chk("tie_flag", {31'b0, timeout_flag}, 32'h0);
    m0_valid = 1'b0; s_ready = 1'b0;
    tick();

    // Clear coincident with a timeout set
    m0_valid = 1'b1;
    tick();
    repeat (7) tick();
    timeout_clr = 1'b1;
    tick();
    timeout_clr = 1'b0;
    chk("clrset_flag", {31'b0, timeout_flag}, 32'h0);
    chk("clrset_m0_rdata", m0_rdata, 32'h0);
    chk("clrset_m0_ready", {31'b0, m0_ready}, 32'h1);
    m0_valid = 1'b0;
    tick();

    // Reset during an m1 ACCESS
    m1_valid = 1'b1;
    tick();
    chk("mrst_pre_grant", {30'b0, grant}, 32'h2);
    reset_n = 1'b0;
    #1;
    chk("mrst_grant", {30'b0, grant}, 32'h0);
    chk("mrst_s_valid", {31'b0, s_valid}, 32'h0);
    tick();
    chk("mrst_no_ready", {30'b0, m1_ready, m0_ready}, 32'h0);
    chk("mrst_m1_rdata", m1_rdata, 32'h0);
    m0_valid = 1'b1;
    reset_n = 1'b1;
    tick();
    chk("mrst_first_grant", {30'b0, grant}, 32'h1);
    m0_valid = 1'b0; m1_valid = 1'b0;
    tick(); tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
